// File: rtl/fp_pkg.sv
// Shared definitions for the sequential binary32 multiplier: field widths,
// special-value encodings and the controller state type.
package fp_pkg;

   localparam int EXP_W  = 8;
   localparam int FRAC_W = 23;
   localparam int MANT_W = 24;
   localparam int PROD_W = 48;
   localparam int SEXP_W = 10;

   localparam logic [SEXP_W-1:0] EXP_BIAS  = 10'd127;
   localparam logic [4:0]        MULT_LAST = 5'd23;

   localparam logic [31:0] QNAN    = 32'h7FC0_0000;
   localparam logic [31:0] POS_INF = 32'h7F80_0000;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      UNPACK = 3'd1,
      MULT   = 3'd2,
      NORM   = 3'd3,
      ROUND  = 3'd4,
      DONE   = 3'd5
   } fp_state_e;

   // Denormals are flushed, so any zero exponent counts as zero.
   function automatic logic fp_is_zero(input logic [31:0] x);
      return (x[30:23] == 8'd0);
   endfunction

   function automatic logic fp_is_inf(input logic [31:0] x);
      return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
   endfunction

   function automatic logic fp_is_nan(input logic [31:0] x);
      return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
   endfunction

endpackage

// File: rtl/fpm_mant_mul.sv
// 24x24 iterative shift-add significand multiplier; one partial product per
// step, loaded and stepped by the fp_mul_seq controller.
module fpm_mant_mul
   import fp_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              step,
   input  logic [MANT_W-1:0] mcand,
   input  logic [MANT_W-1:0] mplier,
   output logic [PROD_W-1:0] product,
   output logic [4:0]        count
);

   logic [PROD_W-1:0] acc_r;
   logic [PROD_W-1:0] mcand_r;
   logic [MANT_W-1:0] mplier_r;
   logic [4:0]        count_r;

   // Accumulate the shifted multiplicand for each set multiplier bit, LSB first.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_r    <= {PROD_W{1'b0}};
         mcand_r  <= {PROD_W{1'b0}};
         mplier_r <= {MANT_W{1'b0}};
         count_r  <= 5'd0;
      end else if (load) begin
         acc_r    <= {PROD_W{1'b0}};
         mcand_r  <= {{(PROD_W-MANT_W){1'b0}}, mcand};
         mplier_r <= mplier;
         count_r  <= 5'd0;
      end else if (step) begin
         if (mplier_r[0]) begin
            acc_r <= acc_r + mcand_r;
         end else begin
            acc_r <= acc_r;
         end
         mcand_r  <= {mcand_r[PROD_W-2:0], 1'b0};
         mplier_r <= {1'b0, mplier_r[MANT_W-1:1]};
         count_r  <= count_r + 5'd1;
      end else begin
         acc_r    <= acc_r;
         mcand_r  <= mcand_r;
         mplier_r <= mplier_r;
         count_r  <= count_r;
      end
   end

   assign product = acc_r;
   assign count   = count_r;

endmodule

// File: rtl/fp_mul_seq.sv
// Sequential IEEE-754 binary32 multiplier (flush-to-zero). Define FPMUL_ROUND_EN
// for round-to-nearest-even; otherwise the significand is truncated.
module fp_mul_seq
   import fp_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] result,
   output logic [2:0]  flags
);

`ifdef FPMUL_ROUND_EN
   localparam logic RND_EN = 1'b1;
`else
   localparam logic RND_EN = 1'b0;
`endif

   fp_state_e                state_r, state_s;
   logic [31:0]              a_r, b_r;
   logic                     sign_r;
   logic signed [SEXP_W-1:0] exp_r;
   logic [FRAC_W-1:0]        frac_r;
   logic                     guard_r, round_r, sticky_r;
   logic [31:0]              result_r, res_s;
   logic [2:0]               flags_r, flg_s;
   logic                     busy_r, done_r;

   logic                     load_s, step_s;
   logic [PROD_W-1:0]        product_s;
   logic [4:0]               count_s;

   logic                     sign_s, spec_s;
   logic [31:0]              spec_res_s;
   logic [2:0]               spec_flg_s;

   logic                     inc_s;
   logic [FRAC_W:0]          frac_sum_s;
   logic signed [SEXP_W-1:0] exp_rnd_s;
   logic [FRAC_W-1:0]        frac_rnd_s;
   logic [31:0]              rnd_res_s;
   logic [2:0]               rnd_flg_s;

   fpm_mant_mul u_mant_mul (
      .clk     (clk),
      .rst     (rst),
      .load    (load_s),
      .step    (step_s),
      .mcand   ({1'b1, a_r[22:0]}),
      .mplier  ({1'b1, b_r[22:0]}),
      .product (product_s),
      .count   (count_s)
   );

   // Classify the captured operands and pick the special-case result, if any.
   always_comb begin
      sign_s     = a_r[31] ^ b_r[31];
      spec_s     = 1'b1;
      spec_res_s = 32'd0;
      spec_flg_s = 3'b000;
      if (fp_is_nan(a_r) || fp_is_nan(b_r) ||
          (fp_is_inf(a_r) && fp_is_zero(b_r)) ||
          (fp_is_zero(a_r) && fp_is_inf(b_r))) begin
         spec_res_s = QNAN;
         spec_flg_s = 3'b100;
      end else if (fp_is_inf(a_r) || fp_is_inf(b_r)) begin
         spec_res_s = {sign_s, POS_INF[30:0]};
      end else if (fp_is_zero(a_r) || fp_is_zero(b_r)) begin
         spec_res_s = {sign_s, 31'd0};
      end else begin
         spec_s = 1'b0;
      end
   end

   // Round (or truncate), absorb a significand carry, then range-check the exponent.
   always_comb begin
      inc_s      = RND_EN & guard_r & (round_r | sticky_r | frac_r[0]);
      frac_sum_s = {1'b0, frac_r} + {{FRAC_W{1'b0}}, inc_s};
      if (frac_sum_s[FRAC_W]) begin
         exp_rnd_s  = exp_r + 10'sd1;
         frac_rnd_s = {FRAC_W{1'b0}};
      end else begin
         exp_rnd_s  = exp_r;
         frac_rnd_s = frac_sum_s[FRAC_W-1:0];
      end
      if (exp_rnd_s >= 10'sd255) begin
         rnd_res_s = {sign_r, POS_INF[30:0]};
         rnd_flg_s = 3'b010;
      end else if (exp_rnd_s <= 10'sd0) begin
         rnd_res_s = {sign_r, 31'd0};
         rnd_flg_s = 3'b001;
      end else begin
         rnd_res_s = {sign_r, exp_rnd_s[EXP_W-1:0], frac_rnd_s};
         rnd_flg_s = 3'b000;
      end
   end

   // Controller next state, multiplier control and the result to be registered.
   always_comb begin
      state_s = state_r;
      load_s  = 1'b0;
      step_s  = 1'b0;
      res_s   = result_r;
      flg_s   = flags_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_s = UNPACK;
            end else begin
               state_s = IDLE;
            end
         end
         UNPACK: begin
            if (spec_s) begin
               state_s = DONE;
               res_s   = spec_res_s;
               flg_s   = spec_flg_s;
            end else begin
               state_s = MULT;
               load_s  = 1'b1;
            end
         end
         MULT: begin
            step_s = 1'b1;
            if (count_s == MULT_LAST) begin
               state_s = NORM;
            end else begin
               state_s = MULT;
            end
         end
         NORM:    state_s = ROUND;
         ROUND: begin
            state_s = DONE;
            res_s   = rnd_res_s;
            flg_s   = rnd_flg_s;
         end
         DONE:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // State, registered outputs and the per-stage datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= IDLE;
         a_r      <= 32'd0;
         b_r      <= 32'd0;
         sign_r   <= 1'b0;
         exp_r    <= 10'sd0;
         frac_r   <= {FRAC_W{1'b0}};
         guard_r  <= 1'b0;
         round_r  <= 1'b0;
         sticky_r <= 1'b0;
         result_r <= 32'd0;
         flags_r  <= 3'b000;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         state_r  <= state_s;
         result_r <= res_s;
         flags_r  <= flg_s;
         busy_r   <= (state_s != IDLE);
         done_r   <= (state_s == DONE);
         case (state_r)
            IDLE: begin
               if (start) begin
                  a_r <= a;
                  b_r <= b;
               end
            end
            UNPACK: begin
               sign_r <= sign_s;
               exp_r  <= $signed({2'b00, a_r[30:23]} + {2'b00, b_r[30:23]} - EXP_BIAS);
            end
            // A product in [2,4) carries its leading one at bit 47.
            NORM: begin
               if (product_s[47]) begin
                  exp_r    <= exp_r + 10'sd1;
                  frac_r   <= product_s[46:24];
                  guard_r  <= product_s[23];
                  round_r  <= product_s[22];
                  sticky_r <= |product_s[21:0];
               end else begin
                  frac_r   <= product_s[45:23];
                  guard_r  <= product_s[22];
                  round_r  <= product_s[21];
                  sticky_r <= |product_s[20:0];
               end
            end
            default: begin
               sign_r <= sign_r;
            end
         endcase
      end
   end

   assign busy   = busy_r;
   assign done   = done_r;
   assign result = result_r;
   assign flags  = flags_r;

endmodule

// File: tb/tb_fp_mul_seq.sv
// Self-checking bench for fp_mul_seq: cycle-level reference model plus directed
// vectors with hand-computed results.
module tb_fp_mul_seq;

   logic        clk = 1'b0;
   logic        rst, start;
   logic [31:0] a, b;
   logic        busy, done;
   logic [31:0] result;
   logic [2:0]  flags;

   int n_checks = 0;
   int n_fail   = 0;
   logic chk_en = 1'b0;

   always #5 clk = ~clk;

   fp_mul_seq dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result),
      .flags  (flags)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Returns {special_path, flags[2:0], result[31:0]} from plain arithmetic.
   function automatic logic [35:0] model_fp(input logic [31:0] x, input logic [31:0] y);
      logic s, zx, zy, ix, iy, nx, ny;
      int ex, ey, e, sh;
      longint unsigned p, m;
      s  = x[31] ^ y[31];
      ex = int'(x[30:23]);
      ey = int'(y[30:23]);
      zx = (ex == 0);
      zy = (ey == 0);
      ix = (ex == 255) && (x[22:0] == 23'd0);
      iy = (ey == 255) && (y[22:0] == 23'd0);
      nx = (ex == 255) && (x[22:0] != 23'd0);
      ny = (ey == 255) && (y[22:0] != 23'd0);
      if (nx || ny || (ix && zy) || (zx && iy)) return {1'b1, 3'b100, 32'h7FC0_0000};
      if (ix || iy) return {1'b1, 3'b000, s, 8'hFF, 23'd0};
      if (zx || zy) return {1'b1, 3'b000, s, 31'd0};
      p  = 64'({1'b1, x[22:0]}) * 64'({1'b1, y[22:0]});
      e  = ex + ey - 127;
      sh = 23;
      if (p >= (64'd1 << 47)) begin
         sh = 24;
         e  = e + 1;
      end
      m = p >> sh;
`ifdef FPMUL_ROUND_EN
      begin
         longint unsigned rem, half;
         rem  = p - (m << sh);
         half = 64'd1 << (sh - 1);
         if (rem > half || (rem == half && m[0])) m = m + 64'd1;
      end
`endif
      if (m == (64'd1 << 24)) begin
         m = 64'd1 << 23;
         e = e + 1;
      end
      if (e >= 255) return {1'b0, 3'b010, s, 8'hFF, 23'd0};
      if (e <= 0)   return {1'b0, 3'b001, s, 31'd0};
      return {1'b0, 3'b000, s, 8'(e), m[22:0]};
   endfunction

   logic [35:0] mv_s;
   assign mv_s = model_fp(a, b);

   logic        m_busy = 1'b0, m_done = 1'b0;
   logic [31:0] m_res  = 32'd0;
   logic [2:0]  m_flg  = 3'b000;
   logic [34:0] m_pend = 35'd0;
   int          m_cnt  = 0;

   // Reference timeline: latency countdown from the sampling edge.
   always @(posedge clk) begin
      if (rst) begin
         m_busy <= 1'b0;
         m_done <= 1'b0;
         m_res  <= 32'd0;
         m_flg  <= 3'b000;
         m_cnt  <= 0;
      end else if (m_done) begin
         m_done <= 1'b0;
         m_busy <= 1'b0;
      end else if (!m_busy) begin
         if (start) begin
            m_pend <= mv_s[34:0];
            m_busy <= 1'b1;
            m_cnt  <= mv_s[35] ? 1 : 27;
         end
      end else if (m_cnt == 1) begin
         m_done <= 1'b1;
         m_res  <= m_pend[31:0];
         m_flg  <= m_pend[34:32];
         m_cnt  <= 0;
      end else begin
         m_cnt <= m_cnt - 1;
      end
   end

   // Every cycle, compare all outputs against the reference.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy",   32'(busy),  32'(m_busy));
         chk("done",   32'(done),  32'(m_done));
         chk("result", result,     m_res);
         chk("flags",  32'(flags), 32'(m_flg));
      end
   end

   task automatic run_op(input logic [31:0] xa, input logic [31:0] xb, input bit lit,
                         input logic [31:0] e_res, input logic [2:0] e_flg, input int e_lat);
      int edges;
      logic [35:0] mv;
      mv = model_fp(xa, xb);
      @(posedge clk); #1;
      a = xa; b = xb; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      a = $urandom; b = $urandom;
      edges = 1;
      while (edges < 60) begin
         @(negedge clk);
         if (done) break;
         @(posedge clk);
         edges++;
      end
      if (lit) begin
         chk("lit_result", result, e_res);
         chk("lit_flags", 32'(flags), 32'(e_flg));
         chk("lit_latency", 32'(edges), 32'(e_lat));
         chk("model_pin", mv[31:0], e_res);
      end else begin
         chk("latency", 32'(edges), mv[35] ? 32'd2 : 32'd28);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int pulses, first, second;
      rst = 1'b1; start = 1'b0; a = 32'd0; b = 32'd0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);
      chk("rst_busy",   32'(busy),  32'd0);
      chk("rst_done",   32'(done),  32'd0);
      chk("rst_result", result,     32'd0);
      chk("rst_flags",  32'(flags), 32'd0);

      run_op(32'h3FC0_0000, 32'h4000_0000, 1'b1, 32'h4040_0000, 3'b000, 28);
      run_op(32'h8000_0000, 32'h3F80_0000, 1'b1, 32'h8000_0000, 3'b000, 2);
      run_op(32'h7F80_0000, 32'h0000_0000, 1'b1, 32'h7FC0_0000, 3'b100, 2);
      run_op(32'h7F00_0000, 32'h4000_0000, 1'b1, 32'h7F80_0000, 3'b010, 28);
      run_op(32'h0080_0000, 32'h0080_0000, 1'b1, 32'h0000_0000, 3'b001, 28);
`ifdef FPMUL_ROUND_EN
      run_op(32'h3FC0_0001, 32'h3FC0_0001, 1'b1, 32'h4010_0002, 3'b000, 28);
`else
      run_op(32'h3FC0_0001, 32'h3FC0_0001, 1'b1, 32'h4010_0001, 3'b000, 28);
`endif
      run_op(32'hC000_0000, 32'h4040_0000, 1'b1, 32'hC0C0_0000, 3'b000, 28);
      run_op(32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h3F80_0000, 3'b000, 28);
      run_op(32'h7F80_0001, 32'h3F80_0000, 1'b1, 32'h7FC0_0000, 3'b100, 2);
      run_op(32'hFF80_0000, 32'h4000_0000, 1'b1, 32'hFF80_0000, 3'b000, 2);
      run_op(32'h0000_0001, 32'h3F80_0000, 1'b1, 32'h0000_0000, 3'b000, 2);
      for (int i = 0; i < 6; i++) begin
         run_op({1'($urandom), 8'($urandom_range(64, 190)), 23'($urandom)},
                {1'($urandom), 8'($urandom_range(64, 190)), 23'($urandom)},
                1'b0, 32'd0, 3'b000, 0);
      end

      // start held high: second operation begins the cycle IDLE is re-entered
      @(posedge clk); #1;
      a = 32'h3FC0_0000; b = 32'h4000_0000; start = 1'b1;
      pulses = 0; first = 0; second = 0;
      for (int i = 1; i <= 70; i++) begin
         @(posedge clk); #1;
         if (i == 40) start = 1'b0;
         @(negedge clk);
         if (done) begin
            pulses++;
            if (pulses == 1) first = i;
            else second = i;
         end
      end
      chk("hold_pulses", 32'(pulses), 32'd2);
      chk("hold_spacing", 32'(second - first), 32'd29);

      // reset on edge 10 of an operation discards it
      @(posedge clk); #1;
      a = 32'h3FC0_0000; b = 32'h4000_0000; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (8) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_busy",   32'(busy),  32'd0);
      chk("midrst_done",   32'(done),  32'd0);
      chk("midrst_result", result,     32'd0);
      chk("midrst_flags",  32'(flags), 32'd0);
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) pulses++;
      end
      chk("midrst_no_done", 32'(pulses), 32'd0);

      run_op(32'h3FC0_0000, 32'h4000_0000, 1'b1, 32'h4040_0000, 3'b000, 28);
      @(posedge clk);
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fp_mul_seq.md
FP_MUL_SEQ -- requirements
Module: fp_mul_seq

Interface
REQ-001 Parameters: none; the format is fixed at IEEE-754 binary32 (1 sign, 8 exponent, 23 fraction, bias 127).
REQ-002 clk  in  1  single clock; all state changes on the rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 start  in  1  request; sampled only while idle.
REQ-005 a  in  32  operand A, binary32.
REQ-006 b  in  32  operand B, binary32.
REQ-007 busy  out  1  high in every state except IDLE.
REQ-008 done  out  1  one-cycle pulse; result is valid in that cycle.
REQ-009 result  out  32  product, binary32; held until the next accepted start.
REQ-010 flags  out  3  {nan, overflow, underflow}; updated with result and held with it.

Function
REQ-011 FSM states: IDLE, UNPACK, MULT, NORM, ROUND, DONE.
- IDLE->UNPACK on start=1; a and b are captured on that edge.
REQ-012 UNPACK, 1 cycle:
- sign = a[31]^b[31].
- Classify both operands: zero/denormal (exp=0, flushed to zero), inf, NaN.
- Special case -> DONE; otherwise -> MULT.
- exp_sum = ea+eb-127, held in a 10-bit signed register.
REQ-013 MULT, exactly 24 cycles:
- Shift-add over the 24-bit significands {1,frac} into a 48-bit product.
- A 5-bit counter runs 0..23; the FSM leaves MULT when the count reaches 23.
REQ-014 NORM, 1 cycle:
- If product[47]=1: shift right by 1 and exp_sum+1.
- Sticky = OR of all discarded bits below the guard bit.
REQ-015 ROUND, 1 cycle: behaviour per REQ-022/023.
- A rounding carry out of the significand increments the exponent and sets fraction=0.
REQ-016 Range check after ROUND:
- exp>=255 -> result = signed inf, overflow=1.
- exp<=0 -> result = signed zero, underflow=1.
REQ-017 Special results, decided in UNPACK:
- NaN operand, or inf*zero -> 0x7FC00000, nan=1.
- inf*(nonzero) -> signed inf.
- zero*(finite) -> signed zero.
REQ-018 DONE, 1 cycle: done=1, result/flags registered, then ->IDLE.
REQ-019 Latency, counted in edges after the edge that samples start:
- Normal path: done high after edge 28.
- Special path: done high after edge 2.
REQ-020 start while busy is ignored and produces no queueing.
- start in the DONE cycle is ignored.
- start in the cycle IDLE is re-entered is accepted.
REQ-021 a and b may change after start is sampled without affecting the operation.

Configuration
REQ-022 With FPMUL_ROUND_EN defined: round to nearest, ties to even, using guard, round and sticky bits.
REQ-023 Without FPMUL_ROUND_EN: truncate; ROUND still takes 1 cycle, so latency is identical.

Reset
REQ-024 rst=1 at any edge, including mid-operation, sets:
- state=IDLE, counter=0, busy=0, done=0, result=0, flags=0.
- The in-flight operation is discarded.
REQ-025 An operation starting the cycle after reset release behaves as from power-up.

Structure
REQ-026 Shared package fp_pkg holds:
- Field widths, EXP_BIAS=127.
- Constants QNAN=0x7FC00000 and POS_INF=0x7F800000.
- The FSM state enum.
REQ-027 One sub-module, fpm_mant_mul: a 24x24 iterative shift-add multiplier with load/step/count ports, driven by the FSM.
- Exponent, sign, rounding and packing stay in fp_mul_seq.

Verification
REQ-028 0x3FC00000 * 0x40000000 -> result 0x40400000, flags 0, done after edge 28, busy high over edges 1..28.
REQ-029 0x80000000 * 0x3F800000 -> result 0x80000000, done after edge 2.
- 0x7F800000 * 0x00000000 -> result 0x7FC00000, nan=1.
REQ-030 0x7F000000 * 0x40000000 -> result 0x7F800000, overflow=1.
- 0x00800000 * 0x00800000 -> result 0x00000000, underflow=1.
REQ-031 0x3FC00001 * 0x3FC00001 -> 0x40100002 with FPMUL_ROUND_EN, 0x40100001 without.
REQ-032 Handshake and reset:
- start held high for 40 cycles -> exactly two done pulses, 29 edges apart.
- rst at edge 10 of an operation -> no done; all outputs 0 next cycle.
